// File: rtl/framebuffer_scanout.sv
// -----------------------------------------------------------------------------
// framebuffer_scanout
//   Read-side engine of the framebuffer. Generates VGA-style raster timing and
//   streams RGB565 pixels out of framebuffer port B, upscaling each FB word to a
//   2^SCALE_SHIFT x 2^SCALE_SHIFT block of screen pixels.
//
//   Optional feature macro: FB_SCANOUT_BORDER_EN
//     defined   -> visible pixels outside the FB area show BORDER_COLOR
//     undefined -> those pixels are black (16'h0000)
//
// Ports
//   clk            pixel clock (same clock as the framebuffer read port)
//   reset          synchronous, active-high; aborts scanout immediately
//   enable         level; start / continue scanout
//   base_address   word base of the displayed buffer, latched once per frame
//   fb_address     read address to the framebuffer
//   fb_read_enable high when fb_address is a valid read this cycle
//   fb_data        framebuffer read data, valid one clock after the address
//   pixel          RGB565 output pixel
//   data_enable    pixel lies in the visible area
//   hsync, vsync   active-low sync pulses, aligned with pixel
//   frame_start    one-clock pulse with the first visible pixel of a frame
//   busy           high while running or draining the current frame
// -----------------------------------------------------------------------------
module framebuffer_scanout #(
   parameter int          H_ACTIVE      = 640,
   parameter int          H_FRONT       = 16,
   parameter int          H_SYNC        = 96,
   parameter int          H_BACK        = 48,
   parameter int          V_ACTIVE      = 480,
   parameter int          V_FRONT       = 10,
   parameter int          V_SYNC        = 2,
   parameter int          V_BACK        = 33,
   parameter int          FB_WIDTH_LOG2 = 6,
   parameter int          FB_HEIGHT     = 48,
   parameter int          SCALE_SHIFT   = 3,
   parameter logic [15:0] BORDER_COLOR  = 16'h001F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [16:0] base_address,
   output logic [16:0] fb_address,
   output logic        fb_read_enable,
   input  logic [15:0] fb_data,
   output logic [15:0] pixel,
   output logic        data_enable,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start,
   output logic        busy
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS_END  = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_VIS_END  = VW'(V_ACTIVE);
   localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FRONT);
   localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FRONT);
   localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [16:0]   FB_W       = 17'(2 ** FB_WIDTH_LOG2);
   localparam logic [16:0]   FB_H       = 17'(FB_HEIGHT);
   localparam logic [16:0]   FB_X_MASK  = FB_W - 17'd1;

`ifdef FB_SCANOUT_BORDER_EN
   localparam logic [15:0] FILL_COLOR = BORDER_COLOR;
`else
   // Outside the FB area the screen is black; the border colour is masked away.
   localparam logic [15:0] FILL_COLOR = BORDER_COLOR & 16'h0000;
`endif

   // Control bits carried down the pipeline alongside the memory read.
   localparam int C_DE   = 0;
   localparam int C_INFB = 1;
   localparam int C_HS   = 2;
   localparam int C_VS   = 3;
   localparam int C_FS   = 4;
   localparam int CW     = 5;
   localparam logic [CW-1:0] CTRL_IDLE = 5'b01100;   // syncs high, all else low
   localparam int PIPE_STAGES = 2;                    // address stage, data stage

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   state_t          state_reg, state_next;
   logic [HW-1:0]   h_count_reg, h_count_next;
   logic [VW-1:0]   v_count_reg, v_count_next;
   logic [16:0]     base_reg;
   logic [16:0]     fb_address_reg;
   logic [CW-1:0]   ctrl_reg [PIPE_STAGES];
   logic [15:0]     pixel_reg;
   logic            de_reg, hs_reg, vs_reg, fs_reg;

   logic            active;
   logic            frame_origin;
   logic            frame_end;
   logic            visible;
   logic            in_fb;
   logic [16:0]     fb_x, fb_y;
   logic [16:0]     base_eff;
   logic [16:0]     addr_now;
   logic [CW-1:0]   ctrl_now;

   // The raster advances in any cycle where scanout is live, including the
   // IDLE cycle that sees enable, so the first pixel leaves 3 clocks later.
   assign active       = (state_reg != ST_IDLE) || enable;
   assign frame_origin = (h_count_reg == '0) && (v_count_reg == '0);
   assign frame_end    = (h_count_reg == H_LAST) && (v_count_reg == V_LAST);

   always_comb begin
      state_next   = state_reg;
      h_count_next = '0;
      v_count_next = '0;
      case (state_reg)
         ST_IDLE:  if (enable) state_next = ST_RUN;
         ST_RUN:   if (!enable) state_next = ST_DRAIN;
         ST_DRAIN: begin
            if (enable)         state_next = ST_RUN;
            else if (frame_end) state_next = ST_IDLE;
         end
         default:  state_next = ST_IDLE;
      endcase
      if (active) begin
         if (h_count_reg == H_LAST) begin
            h_count_next = '0;
            v_count_next = (v_count_reg == V_LAST) ? '0 : v_count_reg + 1'b1;
         end else begin
            h_count_next = h_count_reg + 1'b1;
            v_count_next = v_count_reg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         h_count_reg <= '0;
         v_count_reg <= '0;
      end else begin
         state_reg   <= state_next;
         h_count_reg <= h_count_next;
         v_count_reg <= v_count_next;
      end
   end

   // The base is latched at the frame origin; the origin pixel itself uses the
   // live input so a buffer swap applies to the whole new frame and nothing else.
   always_ff @(posedge clk) begin
      if (reset)                      base_reg <= '0;
      else if (active && frame_origin) base_reg <= base_address;
   end

   always_comb begin
      fb_x     = 17'(h_count_reg >> SCALE_SHIFT);
      fb_y     = 17'(v_count_reg >> SCALE_SHIFT);
      visible  = (h_count_reg < H_VIS_END) && (v_count_reg < V_VIS_END);
      in_fb    = visible && (fb_x < FB_W) && (fb_y < FB_H);
      base_eff = frame_origin ? base_address : base_reg;
      addr_now = base_eff + ((fb_y << FB_WIDTH_LOG2) | (fb_x & FB_X_MASK));

      ctrl_now         = CTRL_IDLE;
      ctrl_now[C_DE]   = visible;
      ctrl_now[C_INFB] = in_fb;
      ctrl_now[C_HS]   = !((h_count_reg >= HS_START) && (h_count_reg < HS_END));
      ctrl_now[C_VS]   = !((v_count_reg >= VS_START) && (v_count_reg < VS_END));
      ctrl_now[C_FS]   = frame_origin;
   end

   // Stage 1: address register plus control bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         fb_address_reg <= '0;
         ctrl_reg[0]    <= CTRL_IDLE;
      end else if (active) begin
         if (in_fb) fb_address_reg <= addr_now;
         ctrl_reg[0] <= ctrl_now;
      end else begin
         fb_address_reg <= '0;
         ctrl_reg[0]    <= CTRL_IDLE;
      end
   end

   // Remaining control stages track the memory read latency.
   generate
      for (genvar gi = 1; gi < PIPE_STAGES; gi++) begin : g_ctrl_pipe
         always_ff @(posedge clk) begin
            if (reset) ctrl_reg[gi] <= CTRL_IDLE;
            else       ctrl_reg[gi] <= ctrl_reg[gi-1];
         end
      end
   endgenerate

   // Final stage: pixel selection, aligned with fb_data.
   always_ff @(posedge clk) begin
      if (reset) begin
         pixel_reg <= '0;
         de_reg    <= 1'b0;
         hs_reg    <= 1'b1;
         vs_reg    <= 1'b1;
         fs_reg    <= 1'b0;
      end else begin
         if (!ctrl_reg[PIPE_STAGES-1][C_DE])       pixel_reg <= '0;
         else if (ctrl_reg[PIPE_STAGES-1][C_INFB]) pixel_reg <= fb_data;
         else                                      pixel_reg <= FILL_COLOR;
         de_reg <= ctrl_reg[PIPE_STAGES-1][C_DE];
         hs_reg <= ctrl_reg[PIPE_STAGES-1][C_HS];
         vs_reg <= ctrl_reg[PIPE_STAGES-1][C_VS];
         fs_reg <= ctrl_reg[PIPE_STAGES-1][C_FS];
      end
   end

   assign fb_address     = fb_address_reg;
   assign fb_read_enable = ctrl_reg[0][C_INFB];
   assign pixel          = pixel_reg;
   assign data_enable    = de_reg;
   assign hsync          = hs_reg;
   assign vsync          = vs_reg;
   assign frame_start    = fs_reg;
   assign busy           = (state_reg != ST_IDLE);

endmodule
